ysyx_25050141_dmem_responder: RTL and testbench

//  Data-memory responder: the memory end of the load/store path. Accepts one load or store

---
 rtl/ysyx_25050141_mem_pkg.sv | 49 ++++
 rtl/ysyx_25050141_dmem_responder.sv | 97 +++++++++
 tb/tb_ysyx_25050141_dmem_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25050141_mem_pkg.sv
// Shared load/store memory definitions: responder FSM states, store byte masks, the
// backing-store access functions used by ME and the data-memory responder, and the range check.
package ysyx_25050141_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] WMASK_B = 4'b0001;
  localparam logic [3:0] WMASK_H = 4'b0011;
  localparam logic [3:0] WMASK_W = 4'b1111;

  // Sparse byte-addressed backing store; bytes never written read back as zero.
  logic [7:0]  backing_mem [logic [31:0]];
  int unsigned dpi_read_calls;
  int unsigned dpi_write_calls;

  function automatic logic [31:0] dpi_mem_read(input logic [31:0] addr);
    logic [31:0] data;
    logic [31:0] a;
    data = '0;
    for (int i = 0; i < 4; i++) begin
      a = addr + 32'(i);
      if (backing_mem.exists(a) != 0) data[8*i +: 8] = backing_mem[a];
    end
    dpi_read_calls = dpi_read_calls + 1;
    return data;
  endfunction

  // mask is the zero-extended byte-enable; lane i writes data byte i to addr+i.
  function automatic void dpi_mem_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [7:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (((mask >> i) & 8'h01) != 8'h00) backing_mem[addr + 32'(i)] = data[8*i +: 8];
    end
    dpi_write_calls = dpi_write_calls + 1;
  endfunction

  // 33-bit compare so an address near 32'hFFFF_FFFF cannot wrap into range.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [31:0] size);
    logic [32:0] hi;
    hi = {1'b0, base} + {1'b0, size} - 33'd4;
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= hi);
  endfunction

endpackage

// File: rtl/ysyx_25050141_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it on the backing store
// after LATENCY cycles and holds the response until the requester takes it.
module ysyx_25050141_dmem_responder
  import ysyx_25050141_mem_pkg::*;
#(
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is high only in IDLE outside reset; resp_valid is high exactly in RESP, and
  // resp_rdata/resp_err hold steady there until the response transfer.

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_wen;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wmask;
  logic        req_fire;
  logic        access_now;

  assign req_ready  = (state == IDLE) && !rst;
  assign req_fire   = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign access_now = (state == WAIT) && (cnt == 4'd0);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      cap_wen    <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_wmask  <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (req_fire) begin
        cap_wen   <= req_wen;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_wmask <= req_wmask;
        cnt       <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      // The backing store is touched only here, once per transaction.
      if (access_now) begin
        if (!addr_in_range(cap_addr, MEM_BASE, MEM_SIZE)) begin
          resp_err   <= 1'b1;
          resp_rdata <= 32'd0;
        end else if (cap_wen) begin
          dpi_mem_write(cap_addr, cap_wdata, {4'b0000, cap_wmask});
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end else begin
          resp_err   <= 1'b0;
          resp_rdata <= dpi_mem_read(cap_addr);
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25050141_dmem_responder.sv
// Directed bench for the data-memory responder: one instance at LATENCY=1, one at LATENCY=4,
// sharing the backing store.
module tb_ysyx_25050141_dmem_responder;
  import ysyx_25050141_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wmask  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [1:0]  dbg_state  [2];

  int err_cnt;
  int chk_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_25050141_dmem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  ysyx_25050141_dmem_responder #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int s, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
    req_valid[s] = 1'b1;
    req_wen[s]   = wen;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_wmask[s] = wmask;
  endtask

  // One full transaction; lat is the number of edges from acceptance to resp_valid.
  task automatic txn(input int s, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    drive_req(s, wen, addr, wdata, wmask);
    n = 0;
    while (req_ready[s] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    step();
    req_valid[s] = 1'b0;
    lat = 0;
    while (resp_valid[s] !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    rdata = resp_rdata[s];
    err   = resp_err[s];
    resp_ready[s] = 1'b1;
    step();
    resp_ready[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned wr0;
    int unsigned rd0;

    err_cnt = 0;
    chk_cnt = 0;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]  = 1'b0;
      req_wen[s]    = 1'b0;
      req_addr[s]   = 32'd0;
      req_wdata[s]  = 32'd0;
      req_wmask[s]  = 4'd0;
      resp_ready[s] = 1'b0;
    end

    // Reset held three cycles with requests pending
    drive_req(0, 1'b1, 32'h8000_0040, 32'h1111_1111, WMASK_W);
    drive_req(1, 1'b0, 32'h8000_0040, 32'h0, WMASK_W);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_resp_valid_l1", 32'(resp_valid[0]), 32'd0);
      check("rst_req_ready_l1", 32'(req_ready[0]), 32'd0);
      check("rst_resp_valid_l4", 32'(resp_valid[1]), 32'd0);
      check("rst_req_ready_l4", 32'(req_ready[1]), 32'd0);
    end
    rst = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    check("post_rst_req_ready_l1", 32'(req_ready[0]), 32'd1);
    check("post_rst_req_ready_l4", 32'(req_ready[1]), 32'd1);
    check("post_rst_state", 32'(dbg_state[0]), 32'(IDLE));
    check("post_rst_rdata", resp_rdata[0], 32'd0);
    check("post_rst_err", 32'(resp_err[0]), 32'd0);
    check("post_rst_no_write", dpi_write_calls, 32'd0);
    check("post_rst_no_read", dpi_read_calls, 32'd0);

    // LATENCY=1: word store, load back, byte/half merges, unaligned load
    txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, WMASK_W, rd, er, lat);
    check("sw_lat", 32'(lat), 32'd1);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_write_count", dpi_write_calls, 32'd1);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, WMASK_W, rd, er, lat);
    check("lw_lat", 32'(lat), 32'd1);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_err", 32'(er), 32'd0);
    txn(0, 1'b1, 32'h8000_0011, 32'h0000_00AA, WMASK_B, rd, er, lat);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, WMASK_W, rd, er, lat);
    check("sb_merge", rd, 32'hDEAD_AAEF);
    txn(0, 1'b1, 32'h8000_0012, 32'h0000_1234, WMASK_H, rd, er, lat);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, WMASK_W, rd, er, lat);
    check("sh_merge", rd, 32'h1234_AAEF);
    txn(0, 1'b0, 32'h8000_0011, 32'h0, WMASK_W, rd, er, lat);
    check("lw_unaligned", rd, 32'h0012_34AA);

    // Store with empty mask still reaches the backing store but changes nothing
    wr0 = dpi_write_calls;
    txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    check("sw_mask0_err", 32'(er), 32'd0);
    check("sw_mask0_write_count", dpi_write_calls, wr0 + 1);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, WMASK_W, rd, er, lat);
    check("sw_mask0_unchanged", rd, 32'h1234_AAEF);

    // Out-of-range accesses and the range boundaries
    rd0 = dpi_read_calls;
    wr0 = dpi_write_calls;
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, WMASK_W, rd, er, lat);
    check("lw_low_err", 32'(er), 32'd1);
    check("lw_low_rdata", rd, 32'd0);
    check("lw_low_lat", 32'(lat), 32'd1);
    txn(0, 1'b1, 32'h8800_0000, 32'h1234_5678, WMASK_W, rd, er, lat);
    check("sw_high_err", 32'(er), 32'd1);
    check("sw_high_rdata", rd, 32'd0);
    check("err_no_read", dpi_read_calls, rd0);
    check("err_no_write", dpi_write_calls, wr0);
    check("err_mem_untouched", 32'(backing_mem.exists(32'h8800_0000)), 32'd0);
    txn(0, 1'b0, 32'h87FF_FFFC, 32'h0, WMASK_W, rd, er, lat);
    check("lw_top_ok_err", 32'(er), 32'd0);
    check("lw_top_ok_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h87FF_FFFD, 32'h0, WMASK_W, rd, er, lat);
    check("lw_top_over_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'hFFFF_FFFF, 32'h0, WMASK_W, rd, er, lat);
    check("lw_nowrap_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h8000_0000, 32'h0, WMASK_W, rd, er, lat);
    check("lw_base_err", 32'(er), 32'd0);

    // LATENCY=4 with a stalled response and a second request held on the input
    drive_req(1, 1'b0, 32'h8000_0010, 32'h0, WMASK_W);
    check("l4_ready_idle", 32'(req_ready[1]), 32'd1);
    step();
    wr0 = dpi_write_calls;
    rd0 = dpi_read_calls;
    drive_req(1, 1'b1, 32'h8000_0014, 32'h5566_7788, WMASK_W);
    check("l4_state_wait", 32'(dbg_state[1]), 32'(WAIT));
    for (int c = 0; c < 4; c++) begin
      check("l4_resp_valid_early", 32'(resp_valid[1]), 32'd0);
      check("l4_req_ready_wait", 32'(req_ready[1]), 32'd0);
      step();
    end
    check("l4_resp_valid_rise", 32'(resp_valid[1]), 32'd1);
    check("l4_read_count", dpi_read_calls, rd0 + 1);
    for (int c = 0; c < 5; c++) begin
      check("l4_hold_valid", 32'(resp_valid[1]), 32'd1);
      check("l4_hold_rdata", resp_rdata[1], 32'h1234_AAEF);
      check("l4_hold_err", 32'(resp_err[1]), 32'd0);
      check("l4_hold_req_ready", 32'(req_ready[1]), 32'd0);
      check("l4_hold_state", 32'(dbg_state[1]), 32'(RESP));
      step();
    end
    check("l4_second_not_taken", dpi_write_calls, wr0);
    resp_ready[1] = 1'b1;
    step();
    resp_ready[1] = 1'b0;
    check("l4_valid_after_hs", 32'(resp_valid[1]), 32'd0);
    check("l4_ready_after_hs", 32'(req_ready[1]), 32'd1);
    step();
    req_valid[1] = 1'b0;
    check("l4_second_accepted", 32'(dbg_state[1]), 32'(WAIT));
    for (int c = 0; c < 4; c++) step();
    check("l4_second_valid", 32'(resp_valid[1]), 32'd1);
    check("l4_second_rdata", resp_rdata[1], 32'd0);
    check("l4_second_write", dpi_write_calls, wr0 + 1);
    resp_ready[1] = 1'b1;
    step();
    resp_ready[1] = 1'b0;
    txn(0, 1'b0, 32'h8000_0014, 32'h0, WMASK_W, rd, er, lat);
    check("l4_store_visible", rd, 32'h5566_7788);

    // Reset during WAIT drops the store
    txn(1, 1'b1, 32'h8000_0020, 32'h1122_3344, WMASK_W, rd, er, lat);
    check("l4_sw_lat", 32'(lat), 32'd4);
    wr0 = dpi_write_calls;
    drive_req(1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, WMASK_W);
    step();
    req_valid[1] = 1'b0;
    step();
    check("rst_wait_pre_state", 32'(dbg_state[1]), 32'(WAIT));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_wait_valid", 32'(resp_valid[1]), 32'd0);
    check("rst_wait_state", 32'(dbg_state[1]), 32'(IDLE));
    for (int c = 0; c < 5; c++) step();
    check("rst_wait_no_write", dpi_write_calls, wr0);
    txn(1, 1'b0, 32'h8000_0020, 32'h0, WMASK_W, rd, er, lat);
    check("rst_wait_orig_data", rd, 32'h1122_3344);

    // Reset during RESP drops the response
    drive_req(0, 1'b0, 32'h8000_0010, 32'h0, WMASK_W);
    step();
    req_valid[0] = 1'b0;
    step();
    check("rst_resp_pre_valid", 32'(resp_valid[0]), 32'd1);
    check("rst_resp_pre_rdata", resp_rdata[0], 32'h1234_AAEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_resp_rdata", resp_rdata[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
